// File: rtl/fir_div_pkg.sv
// Shared widths, saturation limits and FSM encoding for the FIR output
// normalisation divider (37-bit signed dividend / 13-bit unsigned divisor).
package fir_div_pkg;

   localparam int N_W   = 37;  // dividend width (signed)
   localparam int D_W   = 13;  // divisor width (unsigned)
   localparam int Q_W   = 24;  // quotient width (signed)
   localparam int R_W   = 14;  // remainder width (signed)
   localparam int CNT_W = 5;   // iteration counter width

   localparam logic signed [Q_W-1:0] QMAX = 24'sh7FFFFF;  //  2^23-1
   localparam logic signed [Q_W-1:0] QMIN = 24'sh800000;  // -2^23

   // Largest quotient magnitude allowed for a negative result (2^23).
   localparam logic [Q_W-1:0] QLIM_NEG = 24'h800000;

   // Counter start value: one iteration per quotient bit.
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(Q_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Saturated quotient for a given result sign.
   function automatic logic [Q_W-1:0] sat_quotient(input logic sn);
      return sn ? QMIN : QMAX;
   endfunction

endpackage

// File: rtl/fir_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module fir_div_step
   import fir_div_pkg::*;
(
   input  logic [R_W-1:0] i_r,    // partial remainder, always < divisor
   input  logic           i_bit,  // next dividend bit, MSB first
   input  logic [D_W-1:0] i_d,    // divisor, non-zero
   output logic [R_W-1:0] o_r,    // updated partial remainder
   output logic           o_q     // quotient bit produced this iteration
);

   logic [R_W-1:0] w_t;
   logic [R_W-1:0] w_d_ext;
   logic [R_W-1:0] w_diff;

   // The remainder is below the divisor, so it fits in R_W-1 bits and the
   // shifted trial value cannot lose its top bit.
   assign w_t     = {i_r[R_W-2:0], i_bit};
   assign w_d_ext = {{(R_W-D_W){1'b0}}, i_d};
   assign w_diff  = w_t - w_d_ext;
   assign o_q     = (w_t >= w_d_ext);
   assign o_r     = o_q ? w_diff : w_t;

endmodule

// File: rtl/fir_div_37s_13ns_24.sv
// Iterative signed-by-unsigned restoring divider used to normalise the FIR
// accumulator. Quotient truncates toward zero and saturates; the remainder
// takes the sign of the dividend.
//
// Handshake: an input transfer happens on a clock edge with
// ce & in_valid & in_ready, an output transfer on a clock edge with
// ce & out_valid & out_ready. in_ready is high only in IDLE and out_valid
// only in DONE, so a new operand is taken only after the previous result
// has left; in_valid seen while busy is ignored and the producer holds
// its data until in_ready.
module fir_div_37s_13ns_24
   import fir_div_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           ce,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N_W-1:0] dividend,
   input  logic [D_W-1:0] divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [Q_W-1:0] quotient,
   output logic [R_W-1:0] remainder,
   output logic           ovf,
   output logic           dbz,
   output state_t         dbg_state
);

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_sn;
   logic [D_W-1:0]   r_d;
   logic [R_W-1:0]   r_r;
   logic [Q_W-1:0]   r_qsh;
   logic [CNT_W-1:0] r_cnt;
   logic [Q_W-1:0]   r_quotient;
   logic [R_W-1:0]   r_remainder;
   logic             r_ovf;
   logic             r_dbz;

   logic [N_W-1:0]   w_an;
   logic [R_W-1:0]   w_step_r;
   logic             w_step_q;
   logic [Q_W-1:0]   w_q_final;
   logic             w_q_over;

   // Magnitude of the dividend; -2^36 maps onto 2^36 as an unsigned value.
   assign w_an = dividend[N_W-1] ? -dividend : dividend;

   // The shift register feeds dividend bits out of its top while quotient
   // bits enter at the bottom; after the last step it holds the magnitude.
   assign w_q_final = {r_qsh[Q_W-2:0], w_step_q};

   // Positive results may reach 2^23-1, negative ones 2^23.
   assign w_q_over = r_sn ? (w_q_final > QLIM_NEG) : w_q_final[Q_W-1];

   fir_div_step u_step (
      .i_r   (r_r),
      .i_bit (r_qsh[Q_W-1]),
      .i_d   (r_d),
      .o_r   (w_step_r),
      .o_q   (w_step_q)
   );

   // Control FSM, iteration datapath and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_sn        <= 1'b0;
         r_d         <= '0;
         r_r         <= '0;
         r_qsh       <= '0;
         r_cnt       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_ovf       <= 1'b0;
         r_dbz       <= 1'b0;
      end else if (ce) begin
         unique case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_sn       <= dividend[N_W-1];
                  r_d        <= divisor;
                  r_in_ready <= 1'b0;
                  if (divisor == '0) begin
                     r_quotient  <= sat_quotient(dividend[N_W-1]);
                     r_remainder <= '0;
                     r_dbz       <= 1'b1;
                     r_ovf       <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end else if (w_an[N_W-1:Q_W] >= divisor) begin
                     // Magnitude would need more than Q_W bits.
                     r_quotient  <= sat_quotient(dividend[N_W-1]);
                     r_remainder <= '0;
                     r_dbz       <= 1'b0;
                     r_ovf       <= 1'b1;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_r     <= {1'b0, w_an[N_W-1:Q_W]};
                     r_qsh   <= w_an[Q_W-1:0];
                     r_cnt   <= CNT_INIT;
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               r_r   <= w_step_r;
               r_qsh <= w_q_final;
               if (r_cnt == '0) begin
                  r_dbz       <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
                  if (w_q_over) begin
                     r_quotient  <= sat_quotient(r_sn);
                     r_remainder <= '0;
                     r_ovf       <= 1'b1;
                  end else begin
                     r_quotient  <= r_sn ? -w_q_final : w_q_final;
                     r_remainder <= r_sn ? -w_step_r : w_step_r;
                     r_ovf       <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign quotient  = r_quotient;
   assign remainder = r_remainder;
   assign ovf       = r_ovf;
   assign dbz       = r_dbz;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_fir_div_37s_13ns_24.sv
// Directed and random checks of the FIR normalisation divider: arithmetic
// against an integer reference model, latency, back-pressure, clock-enable
// stalls and mid-operation reset.
module tb_fir_div_37s_13ns_24;
   import fir_div_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic        ce;
   logic        in_valid;
   logic        in_ready;
   logic [36:0] dividend;
   logic [12:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] quotient;
   logic [13:0] remainder;
   logic        ovf;
   logic        dbz;
   state_t      dbg_state;

   int errors = 0;
   int checks = 0;
   int acc_cnt = 0;

   // Expected result word: {quotient, remainder, ovf, dbz}
   logic [39:0] exp_q[$];

   always #5 clk = ~clk;

   fir_div_37s_13ns_24 dut (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .ovf       (ovf),
      .dbz       (dbz),
      .dbg_state (dbg_state)
   );

   // Edges elapsed since the most recent input transfer (0 right after it).
   always @(posedge clk) begin
      if (!reset && ce && in_valid && in_ready) acc_cnt <= 0;
      else acc_cnt <= acc_cnt + 1;
   end

   // Hard stop in case a wait loop is ever broken.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [39:0] model(input logic [36:0] n, input logic [12:0] d);
      longint nn, an, dd, q, r, lim;
      logic sn;
      logic [23:0] qo;
      logic [13:0] ro;
      nn = longint'($signed(n));
      sn = n[36];
      an = sn ? -nn : nn;
      dd = longint'(d);
      qo = sn ? 24'h800000 : 24'h7FFFFF;
      if (dd == 0) return {qo, 14'd0, 1'b0, 1'b1};
      q = an / dd;
      r = an % dd;
      lim = sn ? 64'sd8388608 : 64'sd8388607;
      if (q > lim) return {qo, 14'd0, 1'b1, 1'b0};
      qo = 24'(sn ? -q : q);
      ro = 14'(sn ? -r : r);
      return {qo, ro, 2'b00};
   endfunction

   // ---------------- check / driver tasks ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present operands until accepted; returns just after the accept edge.
   task automatic send(input string tag, input logic [36:0] n, input logic [12:0] d);
      int k;
      @(negedge clk);
      dividend = n;
      divisor  = d;
      in_valid = 1'b1;
      k = 0;
      while (!(in_ready && ce) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check({tag, " in_ready"}, in_ready, 1'b1);
      exp_q.push_back(model(n, d));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Wait for out_valid; exp_lat < 0 skips the latency check.
   task automatic wait_done(input string tag, input int exp_lat);
      int k;
      k = 0;
      while (!out_valid && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      check({tag, " out_valid"}, out_valid, 1'b1);
      if (exp_lat >= 0) check({tag, " latency"}, acc_cnt, exp_lat);
   endtask

   // Compare the held result against the scoreboard, then take it.
   task automatic take_result(input string tag);
      logic [39:0] e;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 'x;
      check({tag, " quotient"},  quotient,  e[39:16]);
      check({tag, " remainder"}, remainder, e[15:2]);
      check({tag, " ovf"},       ovf,       e[1]);
      check({tag, " dbz"},       dbz,       e[0]);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, " in_ready after take"},  in_ready,  1'b1);
      check({tag, " out_valid after take"}, out_valid, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [36:0] rn;
      logic [12:0] rd;
      logic [39:0] e;

      reset     = 1'b1;
      ce        = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      check("reset state",     dbg_state, IDLE);
      check("reset in_ready",  in_ready,  1'b1);
      check("reset out_valid", out_valid, 1'b0);
      check("reset quotient",  quotient,  24'd0);
      check("reset remainder", remainder, 14'd0);
      check("reset flags",     {ovf, dbz}, 2'b00);

      // Plain division, full iteration latency
      send("t1", 37'sd1000000, 13'd100);
      wait_done("t1", 24);
      take_result("t1");

      // Negative dividend with remainder; quotient zero with large divisor
      send("t2a", -37'sd1000003, 13'd100);
      wait_done("t2a", 24);
      take_result("t2a");
      send("t2b", 37'sd7, 13'd8191);
      wait_done("t2b", 24);
      take_result("t2b");

      // Range edges: -2^23 is legal, +2^23 saturates after the full run
      send("t3a", -37'sd25165824, 13'd3);
      wait_done("t3a", 24);
      take_result("t3a");
      send("t3b", 37'sd25165824, 13'd3);
      wait_done("t3b", 24);
      take_result("t3b");
      // Pre-detected overflow: result is visible right after the accept edge
      send("t3c", 37'd1073741824, 13'd1);
      wait_done("t3c", 0);
      take_result("t3c");

      // Divide by zero
      send("t4a", -37'sd5, 13'd0);
      wait_done("t4a", 0);
      take_result("t4a");
      send("t4b", 37'sd0, 13'd0);
      wait_done("t4b", 0);
      take_result("t4b");

      // Back-pressure: result held, busy input ignored
      send("t5a", -37'sd1000003, 13'd100);
      wait_done("t5a", 24);
      e = exp_q[0];
      dividend = 37'sd5;
      divisor  = 13'd1;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("t5a hold quotient",  quotient,  e[39:16]);
         check("t5a hold remainder", remainder, e[15:2]);
         check("t5a hold in_ready",  in_ready,  1'b0);
         check("t5a hold out_valid", out_valid, 1'b1);
      end
      in_valid = 1'b0;
      take_result("t5a");
      check("t5a back to idle", dbg_state, IDLE);

      // Clock-enable stall of 5 cycles during CALC
      send("t5b", 37'sd1000000, 13'd100);
      repeat (5) @(posedge clk);
      #1;
      ce = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      ce = 1'b1;
      wait_done("t5b", 29);
      take_result("t5b");

      // Reset while CALC counter is at 10 aborts the operation
      send("t6", 37'sd123456, 13'd77);
      repeat (13) @(posedge clk);
      #1;
      check("t6 still calc", dbg_state, CALC);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      void'(exp_q.pop_back());
      check("t6 abort state",     dbg_state, IDLE);
      check("t6 abort in_ready",  in_ready,  1'b1);
      check("t6 abort out_valid", out_valid, 1'b0);
      check("t6 abort outputs",   {quotient, remainder, ovf, dbz}, 40'd0);
      send("t6b", 37'sd1000000, 13'd100);
      wait_done("t6b", 24);
      take_result("t6b");

      // Random operands
      for (int i = 0; i < 8; i++) begin
         rn = 37'($urandom_range(0, 32'h7FFFFFFF));
         if ($urandom_range(0, 1) == 1) rn = -rn;
         rd = 13'($urandom_range(1, 8191));
         send("rnd", rn, rd);
         wait_done("rnd", -1);
         take_result("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
